// File: rtl/mesi_isc_mem_pkg.sv
// Shared definitions for the mbus main-memory controller: mbus command
// encodings (same values as mesi_isc_define), FSM states and CPU count.
package mesi_isc_mem_pkg;

   localparam int CPU_COUNT = 4;

   localparam logic [2:0] MBUS_CMD_NOP      = 3'd0;
   localparam logic [2:0] MBUS_CMD_WR       = 3'd1;
   localparam logic [2:0] MBUS_CMD_RD       = 3'd2;
   localparam logic [2:0] MBUS_CMD_WR_BROAD = 3'd3;
   localparam logic [2:0] MBUS_CMD_RD_BROAD = 3'd4;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      ACK,
      DONE
   } state_t;

   // One-hot select of a CPU id, used for the ack pulse.
   function automatic logic [CPU_COUNT-1:0] cpu_onehot(input logic [1:0] id);
      return CPU_COUNT'(1) << id;
   endfunction

endpackage

// File: rtl/mesi_isc_mem_ctrl_if.sv
// mbus bundle between the four CPU ports and the memory controller.
// All four CPUs' command/address/data lanes are packed side by side.
interface mesi_isc_mem_ctrl_if #(
   parameter int MBUS_CMD_WIDTH = 3,
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32
);

   logic [4*MBUS_CMD_WIDTH-1:0] mbus_cmd_i;
   logic [4*ADDR_WIDTH-1:0]     mbus_addr_i;
   logic [4*DATA_WIDTH-1:0]     mbus_data_i;
   logic [3:0]                  mbus_ack_o;
   logic [DATA_WIDTH-1:0]       mbus_data_o;
   logic                        busy_o;

   // CPU side: issues commands, observes acks and read data.
   modport master (
      output mbus_cmd_i, mbus_addr_i, mbus_data_i,
      input  mbus_ack_o, mbus_data_o, busy_o
   );

   // Memory-controller side.
   modport slave (
      input  mbus_cmd_i, mbus_addr_i, mbus_data_i,
      output mbus_ack_o, mbus_data_o, busy_o
   );

endinterface

// File: rtl/mesi_isc_mem_rr_arb.sv
// Combinational 4-way round-robin pick. The search starts at the CPU after
// rr_last and wraps; rr_last itself is checked last.
module mesi_isc_mem_rr_arb
   import mesi_isc_mem_pkg::*;
(
   input  logic [CPU_COUNT-1:0] req,
   input  logic [1:0]           rr_last,
   output logic                 valid,
   output logic [1:0]           id
);

   // First requester in rotating order after rr_last wins.
   always_comb begin
      // NOTE: defaults assigned up front so no path leaves an output unassigned (no latch).
      valid = 1'b0;
      id    = rr_last;
      for (int i = 1; i <= CPU_COUNT; i++) begin
         if (!valid && req[rr_last + 2'(i)]) begin
            valid = 1'b1;
            id    = rr_last + 2'(i);
         end
      end
   end

endmodule

// File: rtl/mesi_isc_mem_ctrl.sv
// Main-memory controller on the mbus. Grants one CPU WR/RD request at a
// time (round-robin), waits RD_LATENCY cycles, acks for one cycle, then
// spends one DONE cycle so the CPU can drop its command. Broadcast
// commands are left to mesi_isc and never granted here.
module mesi_isc_mem_ctrl
   import mesi_isc_mem_pkg::*;
#(
   parameter int MBUS_CMD_WIDTH = 3,
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int MEM_DEPTH_LOG2 = 8,
   parameter int RD_LATENCY     = 2
) (
   input logic                clk,
   input logic                rst,
   mesi_isc_mem_ctrl_if.slave bus
);

   localparam int MEM_DEPTH = 1 << MEM_DEPTH_LOG2;

   typedef logic [MEM_DEPTH_LOG2-1:0] idx_t;
   typedef logic [DATA_WIDTH-1:0]     word_t;

   // Per-CPU views of the packed bus lanes.
   logic [MBUS_CMD_WIDTH-1:0] cpu_cmd  [CPU_COUNT];
   idx_t                      cpu_idx  [CPU_COUNT];
   word_t                     cpu_data [CPU_COUNT];
   logic [CPU_COUNT-1:0]      req;

   // Only word-index bits of the address matter; the rest alias or are byte offsets.
   logic unused_addr_bits;
   assign unused_addr_bits = ^bus.mbus_addr_i;

   for (genvar n = 0; n < CPU_COUNT; n++) begin : g_cpu
      assign cpu_cmd[n]  = bus.mbus_cmd_i[n*MBUS_CMD_WIDTH +: MBUS_CMD_WIDTH];
      assign cpu_idx[n]  = bus.mbus_addr_i[n*ADDR_WIDTH + 2 +: MEM_DEPTH_LOG2];
      assign cpu_data[n] = bus.mbus_data_i[n*DATA_WIDTH +: DATA_WIDTH];
      assign req[n]      = (cpu_cmd[n] == MBUS_CMD_WIDTH'(MBUS_CMD_WR)) ||
                           (cpu_cmd[n] == MBUS_CMD_WIDTH'(MBUS_CMD_RD));
   end

   // Controller state.
   state_t               state;
   logic [1:0]           rr_last;
   logic [1:0]           gnt_id;
   logic                 gnt_wr;
   idx_t                 gnt_idx;
   word_t                gnt_data;
   logic [3:0]           wait_cnt;
   logic [CPU_COUNT-1:0] ack_q;
   word_t                rd_data_q;
   logic                 busy_q;

   word_t mem [MEM_DEPTH];

   logic       arb_valid;
   logic [1:0] arb_id;

   mesi_isc_mem_rr_arb u_arb (
      .req     (req),
      .rr_last (rr_last),
      .valid   (arb_valid),
      .id      (arb_id)
   );

   // Transaction FSM with registered ack, read data and busy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         rr_last   <= 2'd3;
         gnt_id    <= 2'd0;
         gnt_wr    <= 1'b0;
         gnt_idx   <= '0;
         gnt_data  <= '0;
         wait_cnt  <= 4'd0;
         ack_q     <= '0;
         rd_data_q <= '0;
         busy_q    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register updates from pre-edge values.
         ack_q <= '0;
         case (state)
            IDLE: begin
               if (arb_valid) begin
                  rr_last  <= arb_id;
                  gnt_id   <= arb_id;
                  gnt_wr   <= (cpu_cmd[arb_id] == MBUS_CMD_WIDTH'(MBUS_CMD_WR));
                  gnt_idx  <= cpu_idx[arb_id];
                  gnt_data <= cpu_data[arb_id];
                  wait_cnt <= 4'(RD_LATENCY);
                  busy_q   <= 1'b1;
                  if (RD_LATENCY == 0) begin
                     // No wait cycles: ack and read data straight from the live request.
                     state <= ACK;
                     ack_q <= cpu_onehot(arb_id);
                     if (cpu_cmd[arb_id] != MBUS_CMD_WIDTH'(MBUS_CMD_WR)) begin
                        rd_data_q <= mem[cpu_idx[arb_id]];
                     end
                  end else begin
                     state <= WAIT;
                  end
               end
            end
            WAIT: begin
               wait_cnt <= wait_cnt - 4'd1;
               if (wait_cnt == 4'd1) begin
                  state <= ACK;
                  ack_q <= cpu_onehot(gnt_id);
                  if (!gnt_wr) begin
                     rd_data_q <= mem[gnt_idx];
                  end
               end
            end
            ACK: begin
               state <= DONE;
            end
            DONE: begin
               state  <= IDLE;
               busy_q <= 1'b0;
            end
            default: begin
               state  <= IDLE;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   // Word array; a write commits at the edge that ends ACK.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: this array is reset on purpose (contents must read 0 after reset), so it maps to flops, not RAM.
         for (int i = 0; i < MEM_DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (state == ACK && gnt_wr) begin
         mem[gnt_idx] <= gnt_data;
      end
   end

   assign bus.mbus_ack_o  = ack_q;
   assign bus.mbus_data_o = rd_data_q;
   assign bus.busy_o      = busy_q;

endmodule
